// File: rtl/cnn_pkg.sv
// cnn_pkg: shared state type, default geometry and derived sizes for the conv stream source
package cnn_pkg;
  typedef enum logic [2:0] {IDLE, WEIGHTS, STREAM, FLUSH, DONE} state_t;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_IMG_WIDTH = 8;
  localparam int DEF_IMG_HEIGHT = 8;
  localparam int DEF_FILTER_WIDTH = 4;
  localparam int DEF_FILTER_HEIGHT = 4;
  localparam int NUM_PIXELS = DEF_IMG_WIDTH * DEF_IMG_HEIGHT;
  localparam int NUM_WEIGHTS = DEF_FILTER_WIDTH * DEF_FILTER_HEIGHT;
  localparam int FLUSH_LEN_DEF = (DEF_FILTER_HEIGHT - 1) * DEF_IMG_WIDTH + DEF_FILTER_WIDTH - 1;
  localparam int IMG_AW = $clog2(NUM_PIXELS);
  localparam int WT_AW = $clog2(NUM_WEIGHTS);
endpackage

// File: rtl/conv_stream_source_if.sv
// conv_stream_source_if: weight and pixel stream from the source to the conv kernel
interface conv_stream_source_if #(parameter int DATA_WIDTH = 8);
  logic [DATA_WIDTH-1:0] weight_out;
  logic weight_valid;
  logic [DATA_WIDTH-1:0] pixel_out;
  logic pixel_valid;
  logic pixel_ready;
  logic sof;
  logic eol;
  logic eof;
  logic flushing;
  modport master (output weight_out, weight_valid, pixel_out, pixel_valid, sof, eol, eof, flushing, input pixel_ready);
  modport slave (input weight_out, weight_valid, pixel_out, pixel_valid, sof, eol, eof, flushing, output pixel_ready);
endinterface

// File: rtl/cnn_frame_buffer.sv
// cnn_frame_buffer: simple dual-port frame RAM, synchronous write, 1-cycle synchronous read
module cnn_frame_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH = 64,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic                  clock,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/conv_stream_source.sv
// conv_stream_source: serializes filter weights, then streams the stored frame, then zero flush beats
module conv_stream_source
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int IMG_WIDTH = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
  parameter int FILTER_WIDTH = DEF_FILTER_WIDTH,
  parameter int FILTER_HEIGHT = DEF_FILTER_HEIGHT,
  parameter int FLUSH_LEN = (FILTER_HEIGHT - 1) * IMG_WIDTH + FILTER_WIDTH - 1,
  localparam int NP = IMG_WIDTH * IMG_HEIGHT,
  localparam int NW = FILTER_WIDTH * FILTER_HEIGHT,
  localparam int AW = $clog2(NP),
  localparam int WAW = $clog2(NW)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  img_wr_en,
  input  logic [AW-1:0]         img_wr_addr,
  input  logic [DATA_WIDTH-1:0] img_wr_data,
  input  logic                  wt_wr_en,
  input  logic [WAW-1:0]        wt_wr_addr,
  input  logic [DATA_WIDTH-1:0] wt_wr_data,
  input  logic                  start,
  conv_stream_source_if.master  strm,
  output logic                  busy,
  output logic                  done
);
  localparam int WCW = $clog2(NW + 1);
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam int FCW = $clog2(FLUSH_LEN + 1);
  state_t state;
  logic [DATA_WIDTH-1:0] wt [NW];
  logic [DATA_WIDTH-1:0] rd_data;
  logic [WCW-1:0] wcnt;
  logic [AW-1:0] ptr, rd_addr;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [FCW-1:0] fcnt;
  logic idle, acc, load, flush_go, flush_end, last_col, last_row;
  // ptr is the index of the next pixel to present; the RAM is addressed one ahead on each load
  always_comb begin
    idle = state == IDLE;
    acc = strm.pixel_valid && strm.pixel_ready;
    last_col = col == CW'(IMG_WIDTH - 1);
    last_row = row == RW'(IMG_HEIGHT - 1);
    load = (state == WEIGHTS && wcnt == WCW'(NW)) || (state == STREAM && acc && !strm.eof);
    flush_go = acc && ((state == STREAM && strm.eof) || (state == FLUSH && fcnt != FCW'(FLUSH_LEN - 1)));
    flush_end = acc && state == FLUSH && fcnt == FCW'(FLUSH_LEN - 1);
    rd_addr = load ? ptr + AW'(1) : ptr;
  end
  cnn_frame_buffer #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(NP), .AW(AW)) u_fb (
    .clock(clock),
    .we(idle && img_wr_en),
    .waddr(img_wr_addr),
    .wdata(img_wr_data),
    .raddr(rd_addr),
    .rdata(rd_data)
  );
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      wcnt <= '0;
      fcnt <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      strm.weight_valid <= 1'b0;
      strm.weight_out <= '0;
      for (int i = 0; i < NW; i++) wt[i] <= '0;
    end else begin
      done <= 1'b0;
      if (idle && wt_wr_en) wt[wt_wr_addr] <= wt_wr_data;
      case (state)
        IDLE: if (start) begin
          state <= WEIGHTS;
          busy <= 1'b1;
          wcnt <= WCW'(1);
          strm.weight_valid <= 1'b1;
          // a weight 0 write in the start cycle must reach the first beat
          strm.weight_out <= (wt_wr_en && wt_wr_addr == '0) ? wt_wr_data : wt[0];
        end
        WEIGHTS: if (wcnt == WCW'(NW)) begin
          state <= STREAM;
          wcnt <= '0;
          strm.weight_valid <= 1'b0;
          strm.weight_out <= '0;
        end else begin
          strm.weight_out <= wt[wcnt[WAW-1:0]];
          wcnt <= wcnt + WCW'(1);
        end
        STREAM: if (acc && strm.eof) state <= FLUSH;
        FLUSH: if (flush_end) begin
          state <= DONE;
          busy <= 1'b0;
          done <= 1'b1;
          fcnt <= '0;
        end else if (acc) fcnt <= fcnt + FCW'(1);
        default: state <= IDLE;
      endcase
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      {ptr, col, row} <= '0;
      {strm.pixel_valid, strm.sof, strm.eol, strm.eof, strm.flushing} <= '0;
      strm.pixel_out <= '0;
    end else if (load) begin
      strm.pixel_valid <= 1'b1;
      strm.pixel_out <= rd_data;
      strm.sof <= ptr == '0;
      strm.eol <= last_col;
      strm.eof <= last_col && last_row;
      strm.flushing <= 1'b0;
      ptr <= ptr + AW'(1);
      col <= last_col ? '0 : col + CW'(1);
      row <= last_col ? row + RW'(1) : row;
    end else if (flush_go) begin
      {ptr, col, row} <= '0;
      {strm.sof, strm.eol, strm.eof} <= '0;
      strm.pixel_valid <= 1'b1;
      strm.pixel_out <= '0;
      strm.flushing <= 1'b1;
    end else if (flush_end) begin
      strm.pixel_valid <= 1'b0;
      strm.flushing <= 1'b0;
    end
  end
endmodule

// File: doc/conv_stream_source.md
Name: conv_stream_source

Overview:
- Transmitter side of the conv kernel's input interface.
- Holds one image in a local frame buffer and one filter in a weight register file, both loaded by a host write port.
- On start, serializes the filter weights, then streams the image in raster order, then emits zero flush pixels that drain the kernel's line shift register.
- Sits between the host/DMA loader and the conv kernel instance.

Parameters:
- DATA_WIDTH, 8, bits per pixel and per weight.
- IMG_WIDTH, 8, pixels per row.
- IMG_HEIGHT, 8, rows per frame.
- FILTER_WIDTH, 4, filter columns.
- FILTER_HEIGHT, 4, filter rows.
- FLUSH_LEN, (FILTER_HEIGHT-1)*IMG_WIDTH+FILTER_WIDTH-1 (27 at defaults), zero pixels sent after the frame.

Ports:
- clock  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- img_wr_en  in  1  frame buffer write strobe.
- img_wr_addr  in  clog2(IMG_WIDTH*IMG_HEIGHT)  raster address, row*IMG_WIDTH+col.
- img_wr_data  in  DATA_WIDTH  pixel to store.
- wt_wr_en  in  1  weight write strobe.
- wt_wr_addr  in  clog2(FILTER_WIDTH*FILTER_HEIGHT)  weight index.
- wt_wr_data  in  DATA_WIDTH  weight to store.
- start  in  1  single-cycle request to send one frame.
- pixel_ready  in  1  downstream accepts the current pixel beat.
- weight_out  out  DATA_WIDTH  serialized weight.
- weight_valid  out  1  weight_out valid.
- pixel_out  out  DATA_WIDTH  streamed pixel, or 0 during flush.
- pixel_valid  out  1  pixel_out valid.
- sof  out  1  first pixel of frame.
- eol  out  1  last pixel of a row.
- eof  out  1  last image pixel.
- flushing  out  1  current beat is a flush beat.
- busy  out  1  not IDLE.
- done  out  1  one-cycle pulse, transfer complete.

Behaviour:
- Reset:
  - FSM goes to IDLE.
  - All outputs are 0.
  - Counters and weight registers are cleared to 0.
  - Frame buffer contents are not cleared.
- FSM states and transitions:
  - IDLE -> WEIGHTS when start=1.
  - WEIGHTS -> STREAM after the last weight beat.
  - STREAM -> FLUSH after the beat with index IMG_WIDTH*IMG_HEIGHT-1 is accepted.
  - FLUSH -> DONE after FLUSH_LEN flush beats are accepted.
  - DONE -> IDLE unconditionally.
- Timing: start sampled at cycle T.
  - weight_valid=1 at cycles T+1 .. T+FILTER_WIDTH*FILTER_HEIGHT.
  - Weight k is driven at T+1+k, k ascending from 0.
  - Weights ignore pixel_ready and are never stalled.
  - First pixel beat is valid at T+1+FILTER_WIDTH*FILTER_HEIGHT (T+17 at defaults).
- Handshake:
  - A beat transfers when pixel_valid && pixel_ready.
  - While pixel_ready=0, pixel_out, sof, eol, eof and flushing hold stable and pixel_valid stays 1.
  - With pixel_ready held at 1, one beat transfers per cycle with no bubbles, including across the STREAM->FLUSH boundary.
- Pixel ordering:
  - Beat n carries frame_buffer[n]; col = n mod IMG_WIDTH, row = n / IMG_WIDTH.
  - The col and row counters wrap col IMG_WIDTH-1 -> 0 with row+1.
- Markers:
  - sof=1 only on n=0.
  - eol=1 when col=IMG_WIDTH-1.
  - eof=1 only on n=IMG_WIDTH*IMG_HEIGHT-1, which also has eol=1.
  - All markers are 0 during FLUSH.
- Flush:
  - pixel_out=0, pixel_valid=1, flushing=1.
  - A flush counter counts accepted beats up to FLUSH_LEN.
- Completion:
  - done=1 for one cycle in DONE, which is the cycle after the final flush beat is accepted.
  - busy is 0 in that same cycle.
  - A start in the DONE cycle is ignored; start is accepted again from IDLE on the next cycle.
- Host writes and start while busy:
  - start while busy is ignored.
  - img_wr_en and wt_wr_en while busy are ignored, with no write.
  - In IDLE, writes take effect the next cycle.
  - A write and start in the same IDLE cycle: the write completes first and is used by the transfer.
- Frame buffer:
  - Synchronous-read RAM.
  - The RTL prefetches the next address so back-to-back beats need no bubble.
- Outputs are registered. There is no arithmetic beyond counters; all counters are unsigned.

Decomposition:
- Package cnn_pkg holds:
  - state enum {IDLE, WEIGHTS, STREAM, FLUSH, DONE};
  - the derived constants NUM_PIXELS, NUM_WEIGHTS and FLUSH_LEN default;
  - the address widths.
- One sub-module: cnn_frame_buffer.
  - Simple dual-port RAM, NUM_PIXELS x DATA_WIDTH.
  - One synchronous write port and one synchronous read port with 1-cycle latency.

Test Plan:
1. Load weights wt[k]=k+1 and pixels img[n]=n. Pulse start at T with pixel_ready=1. Expect:
   - weight_out 1..16 at T+1..T+16;
   - pixel_out 0..63 at T+17..T+80, with sof at T+17, eol every 8th beat, eof at T+80;
   - 27 zero beats with flushing=1 at T+81..T+107;
   - done at T+108 and busy=0 there.
2. Backpressure: pixel_ready toggles 1,0,0,1 repeatedly during STREAM and FLUSH. Expect:
   - beats held stable while pixel_ready=0;
   - all 64 values delivered exactly once in order, then exactly 27 flush beats.
3. During STREAM, pulse start and write img_wr_addr=5 with data 0xAA. Expect:
   - no restart;
   - the current frame is unaffected;
   - a later IDLE read-back frame still shows img[5]=5.
4. Assert reset at beat n=20. Expect:
   - next cycle all outputs are 0 and busy=0;
   - a new start replays weights and a full frame from n=0;
   - buffer data is retained.
5. Start pulsed in the done cycle is ignored. Start pulsed the following cycle begins a new transfer, with weight_valid one cycle later.
6. Same-cycle write img[0]=0x7F with start in IDLE -> the first pixel beat carries 0x7F.
